// File: rtl/lmem_pkg.sv
// Shared defaults, bank-select codes and read-tag type for the layer-memory
// arbiter.
package lmem_pkg;

    localparam int LMEM_ADDR_W = 12;
    localparam int LMEM_DATA_W = 20;
    localparam int LMEM_SEL_W  = 3;

    localparam int SEL_NONE = 0;
    localparam int SEL_L0   = 1;
    localparam int SEL_L1   = 3;

    // One stage of the read-return pipeline: is a read in flight, and whose.
    typedef struct packed {
        logic vld;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-client round-robin arbiter with a 1-bit priority pointer.
// The pointer hands priority to the losing client after every grant.
module rr_arbiter2
    import lmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && en) begin
            if (req0 && req1) begin
                gnt0 = !prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/lmem_arbiter.sv
// Arbitrates two clients onto one layer memory: registered strobes one cycle
// after grant, read data returned to its owner two cycles after grant.
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int ADDR_W = LMEM_ADDR_W,
    parameter int DATA_W = LMEM_DATA_W,
    parameter int SEL_W  = LMEM_SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [SEL_W-1:0]  sel0,
    input  logic [SEL_W-1:0]  sel1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              cwr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [SEL_W-1:0]  csel,
    input  logic [DATA_W-1:0] cdata_rd
);

    logic              cwr_q, cwr_d;
    logic              crd_q, crd_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
    logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
    logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
    logic [SEL_W-1:0]  csel_q, csel_d;
    rd_tag_t           tag1_q, tag1_d;
    rd_tag_t           tag2_q, tag2_d;

    logic              gnt_any;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [SEL_W-1:0]  win_sel;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    always_comb begin
        gnt_any   = gnt0 | gnt1;
        win_we    = gnt1 ? we1    : we0;
        win_addr  = gnt1 ? addr1  : addr0;
        win_wdata = gnt1 ? wdata1 : wdata0;
        win_sel   = gnt1 ? sel1   : sel0;
    end

    // Addresses and write data hold between transactions; strobes do not.
    always_comb begin
        cwr_d      = gnt_any & win_we;
        crd_d      = gnt_any & ~win_we;
        caddr_wr_d = cwr_d ? win_addr : caddr_wr_q;
        caddr_rd_d = crd_d ? win_addr : caddr_rd_q;
        cdata_wr_d = cwr_d ? win_wdata : cdata_wr_q;
        csel_d     = gnt_any ? win_sel : SEL_W'(SEL_NONE);
        tag1_d     = '{vld: crd_d, owner: gnt1};
        tag2_d     = tag1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;
    assign rvalid0  = tag2_q.vld & ~tag2_q.owner;
    assign rvalid1  = tag2_q.vld & tag2_q.owner;
    assign rdata    = cdata_rd;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Scoreboard bench for lmem_arbiter: a cycle model queues expected memory-side
// and read-return values at grant time and compares them when they are due.
module tb_lmem_arbiter;

    logic        clk = 1'b0;
    logic        reset, en;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [19:0] wdata0, wdata1;
    logic [2:0]  sel0, sel1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [19:0] rdata;
    logic        cwr, crd;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;
    logic [19:0] cdata_rd;

    always #5 clk = ~clk;

    lmem_arbiter dut (
        .clk(clk), .reset(reset), .en(en),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .sel0(sel0), .sel1(sel1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .csel(csel), .cdata_rd(cdata_rd)
    );

    typedef struct {
        logic        cwr;
        logic        crd;
        logic [2:0]  sel;
        logic [11:0] aw;
        logic [11:0] ar;
        logic [19:0] dw;
    } mexp_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [19:0] d;
    } rexp_t;

    mexp_t       mq[$];
    rexp_t       rq[$];
    logic [19:0] mem [4096];
    logic        m_prio;
    logic [11:0] h_aw, h_ar;
    logic [19:0] h_dw;
    logic        lg0, lg1;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic cyc();
        logic  g0, g1, w, have_e;
        mexp_t e, ne;
        rexp_t r;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset && en) begin
            if (req0 && req1) begin
                g0 = (m_prio == 1'b0);
                g1 = !g0;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        have_e = 1'b0;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            have_e = 1'b1;
            chk("cwr", cwr, e.cwr);
            chk("crd", crd, e.crd);
            chk("csel", csel, e.sel);
            chk("caddr_wr", caddr_wr, e.aw);
            chk("caddr_rd", caddr_rd, e.ar);
            chk("cdata_wr", cdata_wr, e.dw);
        end
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rvalid0", rvalid0, r.v0);
            chk("rvalid1", rvalid1, r.v1);
            if (r.v0 || r.v1) chk("rdata", rdata, r.d);
        end
        ne = '{cwr: 1'b0, crd: 1'b0, sel: 3'd0, aw: 12'd0, ar: 12'd0,
               dw: 20'd0};
        if (reset) begin
            h_aw = '0;
            h_ar = '0;
            h_dw = '0;
            rq.delete();
            rq.push_back('{v0: 1'b0, v1: 1'b0, d: 20'd0});
            rq.push_back('{v0: 1'b0, v1: 1'b0, d: 20'd0});
        end else begin
            w = 1'b0;
            r = '{v0: 1'b0, v1: 1'b0, d: 20'd0};
            if (g0 || g1) begin
                w = g1 ? we1 : we0;
                ne.sel = g1 ? sel1 : sel0;
                if (w) begin
                    ne.cwr = 1'b1;
                    h_aw = g1 ? addr1 : addr0;
                    h_dw = g1 ? wdata1 : wdata0;
                end else begin
                    ne.crd = 1'b1;
                    h_ar = g1 ? addr1 : addr0;
                    r.v0 = g0;
                    r.v1 = g1;
                    r.d = mem[h_ar];
                end
            end
            ne.aw = h_aw;
            ne.ar = h_ar;
            ne.dw = h_dw;
            rq.push_back(r);
        end
        mq.push_back(ne);
        lg0 = g0;
        lg1 = g1;
        @(posedge clk);
        #1;
        if (reset) m_prio = 1'b0;
        else if (g0) m_prio = 1'b1;
        else if (g1) m_prio = 1'b0;
        cdata_rd = (have_e && e.crd) ? mem[e.ar] : 20'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 20'($urandom);
        mem[12'h040] = 20'h00123;
        m_prio = 1'b0;
        h_aw = '0; h_ar = '0; h_dw = '0;
        reset = 1'b1; en = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        sel0 = '0; sel1 = '0; cdata_rd = '0;
        #1;
        idle(2);
        reset = 1'b0;

        // contention from reset: alternating reads
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 12'h010; addr1 = 12'h020; sel0 = 3'd1; sel1 = 3'd3;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("alt_gnt1", lg1, 64'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(3);

        // single write
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h005; wdata0 = 20'h0ABCD;
        sel0 = 3'd1;
        cyc();
        chk("wr_gnt", lg0, 1'b1);
        req0 = 1'b0;
        idle(3);

        // single read
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h040; sel1 = 3'd3;
        cyc();
        req1 = 1'b0;
        idle(3);

        // enable gating
        en = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 12'h100; addr1 = 12'h200; wdata0 = 20'h11111;
        wdata1 = 20'h22222;
        idle(3);
        en = 1'b1;
        cyc();
        chk("en_gnt0", lg0, 1'b1);
        req0 = 1'b0;
        cyc();
        req1 = 1'b0;
        idle(2);

        // reset during an in-flight read
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h077;
        cyc();
        req0 = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle(2);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        cyc();
        chk("rst_prio", lg0, 1'b1);
        req0 = 1'b0;
        cyc();
        req1 = 1'b0;
        idle(2);

        // back-to-back writes from client 1
        req1 = 1'b1; we1 = 1'b1; sel1 = 3'd3;
        for (int i = 0; i < 4; i++) begin
            addr1 = 12'(i);
            wdata1 = 20'(32'h300 + i);
            cyc();
        end
        req1 = 1'b0;
        idle(3);

        // random traffic, requests held until granted
        for (int i = 0; i < 200; i++) begin
            en = ($urandom % 5) != 0;
            if (!req0 && ($urandom % 3 == 0)) begin
                req0 = 1'b1; we0 = 1'($urandom);
                addr0 = 12'($urandom); wdata0 = 20'($urandom);
                sel0 = ($urandom % 2 == 0) ? 3'd1 : 3'd3;
            end
            if (!req1 && ($urandom % 3 == 0)) begin
                req1 = 1'b1; we1 = 1'($urandom);
                addr1 = 12'($urandom); wdata1 = 20'($urandom);
                sel1 = ($urandom % 2 == 0) ? 3'd1 : 3'd3;
            end
            cyc();
            if (lg0) req0 = 1'b0;
            if (lg1) req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
